// File: rtl/unidad_control_mult_if.sv
// unidad_control_mult_if: control/status bundle between the shift-add multiplier controller and its datapath
interface unidad_control_mult_if #(parameter int N = 8);
  logic Inicio;
  logic q0;
  logic CargaQ;
  logic ResetA;
  logic CargaA;
  logic DesplazaQ;
  logic Ocupado;
  logic Fin;
  logic [$clog2(N+1)-1:0] Cuenta;
  modport master (output Inicio, q0, input CargaQ, ResetA, CargaA, DesplazaQ, Ocupado, Fin, Cuenta);
  modport slave (input Inicio, q0, output CargaQ, ResetA, CargaA, DesplazaQ, Ocupado, Fin, Cuenta);
endinterface

// File: rtl/unidad_control_mult.sv
// unidad_control_mult: shift-add multiplier control FSM with separate iteration counter
// Optional macro UC_SUMA_DESPLAZA_EN merges the add and shift steps into one state (one cycle per bit).
module unidad_control_mult #(parameter int N = 8) (
  input logic clk,
  input logic reset,
  unidad_control_mult_if.slave bus
);
  localparam int W = $clog2(N+1);
`ifdef UC_SUMA_DESPLAZA_EN
  typedef enum logic [2:0] {REPOSO, CARGA, SUMA, FIN} state_t;
`else
  typedef enum logic [2:0] {REPOSO, CARGA, SUMA, DESPLAZA, FIN} state_t;
`endif
  state_t state, state_n;
  logic [W-1:0] cuenta;
  logic paso, ultimo;
`ifdef UC_SUMA_DESPLAZA_EN
  assign paso = state == SUMA;
`else
  assign paso = state == DESPLAZA;
`endif
  assign ultimo = cuenta + W'(1) == W'(N);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= REPOSO;
      cuenta <= '0;
    end else begin
      state <= state_n;
      cuenta <= state == CARGA ? '0 : paso ? cuenta + W'(1) : cuenta;
    end
  end
  always_comb begin
    state_n = REPOSO;
    case (state)
      REPOSO:   state_n = bus.Inicio ? CARGA : REPOSO;
      CARGA:    state_n = SUMA;
`ifdef UC_SUMA_DESPLAZA_EN
      SUMA:     state_n = ultimo ? FIN : SUMA;
`else
      SUMA:     state_n = DESPLAZA;
      DESPLAZA: state_n = ultimo ? FIN : SUMA;
`endif
      FIN:      state_n = bus.Inicio ? FIN : REPOSO;
      default:  state_n = REPOSO;
    endcase
  end
  assign bus.CargaQ = state == CARGA;
  assign bus.ResetA = state == CARGA;
  assign bus.CargaA = state == SUMA && bus.q0;
  assign bus.DesplazaQ = paso;
  assign bus.Ocupado = state == CARGA || state == SUMA || paso;
  assign bus.Fin = state == FIN;
  assign bus.Cuenta = cuenta;
endmodule

// File: tb/tb_unidad_control_mult.sv
// tb_unidad_control_mult: randomized scoreboard bench for the multiplier control unit
module tb_unidad_control_mult;
  localparam int N = 8;
`ifdef UC_SUMA_DESPLAZA_EN
  localparam int CPB = 1;
`else
  localparam int CPB = 2;
`endif
  typedef struct {int start; int fin; logic [63:0] pat;} exp_t;
  logic clk = 0;
  logic reset = 0;
  int cyc = 0;
  int pass_cnt = 0;
  int tot_cnt = 0;
  exp_t sb[$];
  logic [63:0] mult = 0;
  logic [63:0] qreg = 0;
  logic [63:0] mask;
  unidad_control_mult_if #(.N(N)) b();
  unidad_control_mult #(.N(N)) dut (.clk(clk), .reset(reset), .bus(b));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask
  // Behavioural datapath: Q loads the multiplier and shifts right, feeding q0 back
  initial begin
    logic ld, sh;
    b.q0 = 0;
    forever begin
      @(negedge clk);
      ld = b.CargaQ;
      sh = b.DesplazaQ;
      @(posedge clk);
      #1;
      if (ld) qreg = mult;
      else if (sh) qreg = qreg >> 1;
      b.q0 = qreg[0];
    end
  end
  // Monitor: rebuilds each operation from observed outputs and compares on Fin rising
  initial begin
    int t_start = 0, idx = 0;
    logic [63:0] pat = 0;
    bit seen = 0, fin_prev = 0, zero_chk = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        fin_prev = 0;
        zero_chk = 0;
      end else begin
        if (zero_chk) begin
          chk("cuenta_restart", b.Cuenta, 0);
          zero_chk = 0;
        end
        if (b.CargaQ) begin
          t_start = cyc;
          pat = 0;
          idx = 0;
          seen = 0;
          zero_chk = 1;
        end
        if (b.CargaA) seen = 1;
        if (b.DesplazaQ) begin
          if (idx < 64) pat[idx] = seen;
          idx++;
          seen = 0;
        end
        if (b.Fin && !fin_prev) begin
          if (sb.size() == 0) chk("unexpected_fin", 1, 0);
          else begin
            e = sb.pop_front();
            chk("start_cycle", t_start, e.start);
            chk("fin_cycle", cyc, e.fin);
            chk("carga_a_bits", pat, e.pat);
            chk("shift_count", idx, N);
            chk("cuenta_fin", b.Cuenta, N);
          end
        end
        fin_prev = b.Fin;
      end
    end
  end
  task automatic run_op(input logic [63:0] m, input bit hold, input bit toggle, input bit at_release);
    bit got = 0;
    if (at_release) reset = 1;
    else begin
      @(posedge clk);
      #1;
    end
    mult = m & mask;
    b.Inicio = 1;
    sb.push_back('{cyc + 1, cyc + 1 + CPB * N + 1, m & mask});
    for (int n = 0; n < CPB * N + 8 && !got; n++) begin
      @(negedge clk);
      if (b.Fin) got = 1;
      else begin
        @(posedge clk);
        #1;
        b.Inicio = toggle ? 1'($urandom_range(0, 1)) : hold;
      end
    end
    chk("fin_seen", got, 1);
    if (got && hold) begin
      b.Inicio = 1;
      repeat (3) begin
        @(negedge clk);
        chk("fin_hold", {b.Fin, b.Ocupado, b.Cuenta == N}, 3'b101);
      end
    end
    b.Inicio = 0;
    @(negedge clk);
    chk("reposo_after_fin", {b.Fin, b.Ocupado, b.CargaQ}, 0);
    chk("cuenta_hold", b.Cuenta, N);
  endtask
  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    mask = {64{1'b1}} >> (64 - N);
    b.Inicio = 0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {b.CargaQ, b.ResetA, b.CargaA, b.DesplazaQ, b.Ocupado, b.Fin, b.Cuenta}, 0);
    reset = 1;
    repeat (3) begin
      @(negedge clk);
      chk("idle", {b.Ocupado, b.Fin, b.Cuenta}, 0);
    end
    run_op(64'hA5, 0, 0, 0);
    run_op(64'hA5, 1, 0, 0);
    for (int i = 0; i < 20; i++)
      run_op({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    @(posedge clk);
    #1;
    mult = 64'h5A & mask;
    b.Inicio = 1;
    repeat (2 + 3 * CPB) @(posedge clk);
    #2;
    chk("cuenta_iter3", b.Cuenta, 3);
    b.Inicio = 0;
    reset = 0;
    #1;
    chk("abort_outputs", {b.CargaQ, b.ResetA, b.CargaA, b.DesplazaQ, b.Ocupado, b.Fin, b.Cuenta}, 0);
    repeat (2) @(negedge clk);
    reset = 1;
    repeat (4) begin
      @(negedge clk);
      chk("idle_after_abort", {b.Ocupado, b.Fin, b.CargaQ}, 0);
    end
    run_op({$urandom, $urandom}, 0, 1, 0);
    reset = 0;
    repeat (2) @(negedge clk);
    run_op({$urandom, $urandom}, 0, 0, 1);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/unidad_control_mult.md
UNIDAD_CONTROL_MULT -- requirements
Module: unidad_control_mult

Interface
REQ-001 Parameter: N, default 8, operand width in bits (number of shift iterations); legal range 2..64.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 Port: Inicio  input  1  start request, level-sampled in REPOSO.
REQ-005 Port: q0  input  1  LSB of datapath register Q.
REQ-006 Port: CargaQ  output  1  load multiplier into Q.
REQ-007 Port: ResetA  output  1  clear accumulator A.
REQ-008 Port: CargaA  output  1  load A with A+M.
REQ-009 Port: DesplazaQ  output  1  shift A:Q right one bit.
REQ-010 Port: Ocupado  output  1  operation in progress.
REQ-011 Port: Fin  output  1  result valid in A:Q.
REQ-012 Port: Cuenta  output  $clog2(N+1)  shifts completed in the current operation.

Function
REQ-013 FSM states SHALL be REPOSO, CARGA, SUMA, DESPLAZA, FIN; the iteration counter SHALL be separate from the state register.
REQ-014 REPOSO: Inicio=1 -> CARGA; else stay.
REQ-015 CARGA: CargaQ=1, ResetA=1, Cuenta cleared to 0; next state SUMA.
REQ-016 SUMA: CargaA = q0 (Mealy on q0); next state DESPLAZA.
REQ-017 DESPLAZA: DesplazaQ=1, Cuenta increments by 1; next state FIN if the incremented Cuenta equals N, else SUMA.
REQ-018 FIN: Fin=1; Inicio=0 -> REPOSO; Inicio=1 -> stay in FIN (no auto-restart, Inicio must drop before the next operation).
REQ-019 Ocupado SHALL be 1 in CARGA, SUMA and DESPLAZA, and 0 in REPOSO and FIN.
REQ-020 Every output not listed for a state SHALL be 0 in that state; CargaQ, ResetA, DesplazaQ, Ocupado and Fin SHALL depend on state only.
REQ-021 Inicio SHALL be ignored while Ocupado=1.
REQ-022 Latency: with Inicio sampled at edge k, CargaQ SHALL be high in cycle k+1 and Fin SHALL first be high in cycle k+2N+2.
REQ-023 Cuenta SHALL never exceed N; it SHALL hold N in FIN and hold its last value in REPOSO.
REQ-024 An unreachable state encoding SHALL transition to REPOSO on the next edge.

Reset
REQ-025 reset=0 SHALL force REPOSO and Cuenta=0 immediately, regardless of clk.
REQ-026 While reset=0, all outputs SHALL be 0.
REQ-027 Reset mid-operation SHALL abort the operation; after release, the block SHALL wait in REPOSO for a new Inicio.
REQ-028 The first rising edge after release SHALL sample Inicio normally.

Configuration
REQ-029 Macro UC_SUMA_DESPLAZA_EN: when defined, SUMA and DESPLAZA SHALL merge into one state.
REQ-030 In the merged state, CargaA=q0, DesplazaQ=1 and Cuenta increments, all in the same cycle.
REQ-031 With the macro defined, Fin SHALL first be high in cycle k+N+2.
REQ-032 Without the macro, behaviour SHALL be exactly as REQ-013..REQ-024 (two cycles per bit).

Verification
REQ-033 N=8, macro off, q0 driven as the bits of Q=0xA5, Inicio pulse -> CargaA asserted in the SUMA cycles of iterations 0,2,5,7 only; 8 DesplazaQ pulses; Fin high at cycle k+18; Cuenta=8.
REQ-034 N=8, macro on, same stimulus -> CargaA and DesplazaQ coincide; Fin high at cycle k+10.
REQ-035 Inicio held high through completion -> block stays in FIN with Fin=1; Inicio=0 -> REPOSO next edge; a new Inicio then restarts with Cuenta=0.
REQ-036 reset=0 pulsed between clock edges during iteration 3 -> all outputs 0 immediately; after release, block stays in REPOSO until Inicio=1.
REQ-037 Inicio toggled during SUMA/DESPLAZA -> no effect on state sequence, Cuenta or Fin timing.
REQ-038 N=2 and N=64 builds -> Fin at k+6 and k+130 respectively (macro off); Cuenta width 2 and 7 bits.
